// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {CS_n, RAS_n, CAS_n, WE_n}
// and the arbiter state encoding.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_REF,
    S_WR,
    S_RD
  } arb_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: raises ref_due once per interval after init, flags a missed refresh.
module sdram_ref_timer #(
  parameter int unsigned REF_CYCLES = 750
) (
  input  logic sclk,
  input  logic srst,
  input  logic init_end,
  input  logic ref_end,
  output logic ref_due,
  output logic ref_miss
);

  localparam int unsigned CntW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REF_CYCLES - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_due;
  logic            r_miss;
  logic            w_tick;

  assign w_tick   = (r_cnt == CntMax);
  assign ref_due  = r_due;
  assign ref_miss = r_miss;

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_cnt  <= '0;
      r_due  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      if (!init_end || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
      // A new interval beats a refresh finishing in the same cycle.
      if (w_tick) begin
        r_due <= 1'b1;
      end else if (ref_end) begin
        r_due <= 1'b0;
      end
      if (w_tick && r_due && !ref_end) begin
        r_miss <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus sequencer: holds the bus for init, then arbitrates refresh/write/read and muxes
// the granted requester onto the device pins.
module sdram_arbit #(
  parameter int unsigned REF_CYCLES = 750,
  parameter logic [3:0]  CMD_NOP    = 4'b0111
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        init_end,
  output logic        ref_en,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic        wr_ask,
  output logic        wr_en,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_ask,
  output logic        rd_en,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        ref_miss
);

  import sdram_pkg::*;

  arb_state_t r_state;
  logic       r_last_wr;
  logic       w_ref_due;

  sdram_ref_timer #(
    .REF_CYCLES(REF_CYCLES)
  ) u_ref_timer (
    .sclk    (sclk),
    .srst    (srst),
    .init_end(init_end),
    .ref_end (ref_end),
    .ref_due (w_ref_due),
    .ref_miss(ref_miss)
  );

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_state   <= S_INIT;
      r_last_wr <= 1'b0;
    end else begin
      unique case (r_state)
        S_INIT: if (init_end) r_state <= S_IDLE;
        S_IDLE: begin
          if (w_ref_due) begin
            r_state <= S_REF;
          end else if (wr_ask && (!rd_ask || !r_last_wr)) begin
            // On a tie, the side not granted last wins.
            r_state   <= S_WR;
            r_last_wr <= 1'b1;
          end else if (rd_ask) begin
            r_state   <= S_RD;
            r_last_wr <= 1'b0;
          end
        end
        S_REF:   if (ref_end) r_state <= S_IDLE;
        S_WR:    if (wr_end) r_state <= S_IDLE;
        S_RD:    if (rd_end) r_state <= S_IDLE;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Dropping the grant while the state holds asks the requester to close its burst.
  assign ref_en = (r_state == S_REF);
  assign wr_en  = (r_state == S_WR) && !w_ref_due;
  assign rd_en  = (r_state == S_RD) && !w_ref_due;

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    unique case (r_state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_REF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_WR: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_RD: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomised bench for sdram_arbit: behavioural bus-ownership model feeds a scoreboard queue.
module tb_sdram_arbit;

  localparam int unsigned RefCycles = 20;
  localparam logic [3:0]  CmdNop    = 4'b0111;
  localparam int          NCycles   = 4000;
  localparam int OInit = 0, OIdle = 1, ORef = 2, OWr = 3, ORd = 4;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  logic [3:0]  init_cmd = '0;
  logic [11:0] init_addr = '0;
  logic        init_end = 1'b0;
  logic        ref_en, ref_end = 1'b0;
  logic [3:0]  ref_cmd = '0;
  logic [11:0] ref_addr = '0;
  logic        wr_ask = 1'b0, wr_en, wr_end = 1'b0;
  logic [3:0]  wr_cmd = '0;
  logic [11:0] wr_addr = '0;
  logic [1:0]  wr_bank = '0;
  logic        rd_ask = 1'b0, rd_en, rd_end = 1'b0;
  logic [3:0]  rd_cmd = '0;
  logic [11:0] rd_addr = '0;
  logic [1:0]  rd_bank = '0;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic        ref_miss;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic        miss;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  sdram_arbit #(
    .REF_CYCLES(RefCycles),
    .CMD_NOP   (CmdNop)
  ) dut (
    .sclk      (sclk),
    .srst      (srst),
    .init_cmd  (init_cmd),
    .init_addr (init_addr),
    .init_end  (init_end),
    .ref_en    (ref_en),
    .ref_end   (ref_end),
    .ref_cmd   (ref_cmd),
    .ref_addr  (ref_addr),
    .wr_ask    (wr_ask),
    .wr_en     (wr_en),
    .wr_end    (wr_end),
    .wr_cmd    (wr_cmd),
    .wr_addr   (wr_addr),
    .wr_bank   (wr_bank),
    .rd_ask    (rd_ask),
    .rd_en     (rd_en),
    .rd_end    (rd_end),
    .rd_cmd    (rd_cmd),
    .rd_addr   (rd_addr),
    .rd_bank   (rd_bank),
    .sdram_cmd (sdram_cmd),
    .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank),
    .ref_miss  (ref_miss)
  );

  always #5 sclk = ~sclk;

  // Monitor: every cycle the DUT presents a bus state, compare it against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ref_en, wr_en, rd_en} !== e.gnt) begin
          failures++;
          $display("FAIL grants t=%0t got ref/wr/rd=%b want=%b", $time,
                   {ref_en, wr_en, rd_en}, e.gnt);
        end
        checks++;
        if ({sdram_cmd, sdram_addr, sdram_bank} !== {e.cmd, e.addr, e.bank}) begin
          failures++;
          $display("FAIL bus t=%0t got cmd=%h addr=%h bank=%h want cmd=%h addr=%h bank=%h",
                   $time, sdram_cmd, sdram_addr, sdram_bank, e.cmd, e.addr, e.bank);
        end
        checks++;
        if (ref_miss !== e.miss) begin
          failures++;
          $display("FAIL ref_miss t=%0t got=%b want=%b", $time, ref_miss, e.miss);
        end
      end
    end
  end

  // Driver + reference model. The model tracks who owns the bus and when each refresh
  // interval expires (cycles since init, modulo the interval).
  initial begin
    int   own      = OInit;
    bit   last_wr  = 1'b0;
    bit   due      = 1'b0;
    bit   miss     = 1'b0;
    int   since    = 0;
    int   w_rem    = 0;
    int   r_rem    = 0;
    int   f_rem    = 0;
    int   init_rel = 100;
    bit   did_rst  = 1'b0;
    bit   rst_now, ie, wa, ra, we, re, fe, tick;
    int   holds[5] = '{8, 8, 19, 25, 0};
    exp_t e;

    for (int n = 0; n < NCycles; n++) begin
      @(posedge sclk);
      #1;
      rst_now = (n < 3);
      if (!did_rst && n >= 1800 && own == OWr) begin
        rst_now  = 1'b1;
        did_rst  = 1'b1;
        init_rel = n + 30;
      end
      ie = !rst_now && (n >= init_rel);

      if (n < 600) begin
        wa = 1'b1;
        ra = 1'b1;
      end else if (n < 1800) begin
        wa = ($urandom_range(0, 1) == 1);
        ra = ($urandom_range(0, 1) == 1);
      end else begin
        wa = ($urandom_range(0, 3) == 0);
        ra = ($urandom_range(0, 3) == 0);
      end

      // Requesters: finish the burst (shortened once the grant is withdrawn), then pulse end.
      we = 1'b0;
      re = 1'b0;
      fe = 1'b0;
      if (!rst_now) begin
        if (own == OWr) begin
          if (due && w_rem > 2) w_rem = 2;
          w_rem--;
          we = (w_rem == 0);
        end else if (own == ORd) begin
          if (due && r_rem > 2) r_rem = 2;
          r_rem--;
          re = (r_rem == 0);
        end else if (own == ORef) begin
          f_rem--;
          fe = (f_rem == 0);
        end
      end

      srst      = rst_now;
      init_end  = ie;
      wr_ask    = wa;
      rd_ask    = ra;
      wr_end    = we;
      rd_end    = re;
      ref_end   = fe;
      init_cmd  = 4'($urandom);
      init_addr = 12'($urandom);
      ref_cmd   = 4'($urandom);
      ref_addr  = 12'($urandom);
      wr_cmd    = 4'($urandom);
      wr_addr   = 12'($urandom);
      wr_bank   = 2'($urandom);
      rd_cmd    = 4'($urandom);
      rd_addr   = 12'($urandom);
      rd_bank   = 2'($urandom);

      e.gnt  = {own == ORef, own == OWr && !due, own == ORd && !due};
      e.miss = miss;
      case (own)
        OInit: begin e.cmd = init_cmd; e.addr = init_addr; e.bank = 2'd0; end
        ORef:  begin e.cmd = ref_cmd;  e.addr = ref_addr;  e.bank = 2'd0; end
        OWr:   begin e.cmd = wr_cmd;   e.addr = wr_addr;   e.bank = wr_bank; end
        ORd:   begin e.cmd = rd_cmd;   e.addr = rd_addr;   e.bank = rd_bank; end
        default: begin e.cmd = CmdNop; e.addr = 12'd0; e.bank = 2'd0; end
      endcase
      exp_q.push_back(e);

      if (rst_now) begin
        own     = OInit;
        last_wr = 1'b0;
        due     = 1'b0;
        miss    = 1'b0;
        since   = 0;
      end else begin
        tick = ie && ((since % RefCycles) == RefCycles - 1);
        since = ie ? since + 1 : 0;
        if (tick && due && !fe) miss = 1'b1;
        case (own)
          OInit: if (ie) own = OIdle;
          OIdle: begin
            if (due) begin
              own   = ORef;
              f_rem = holds[$urandom_range(0, 4)];
              if (f_rem == 0) f_rem = $urandom_range(2, 30);
            end else if (wa && ra) begin
              own     = last_wr ? ORd : OWr;
              last_wr = !last_wr;
            end else if (wa) begin
              own     = OWr;
              last_wr = 1'b1;
            end else if (ra) begin
              own     = ORd;
              last_wr = 1'b0;
            end
            if (own == OWr) w_rem = $urandom_range(2, 8);
            if (own == ORd) r_rem = $urandom_range(2, 8);
          end
          ORef:    if (fe) own = OIdle;
          OWr:     if (we) own = OIdle;
          ORd:     if (re) own = OIdle;
          default: own = OInit;
        endcase
        if (tick) due = 1'b1;
        else if (fe) due = 1'b0;
      end
    end

    @(negedge sclk);
    @(negedge sclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
